// File: rtl/scene_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scene_sequencer
// Description : Frame-rate show controller for the munch / text display.
//               Advances the munch animation counter once per active frame
//               tick. Runs the scene FSM MUNCH -> FADE_IN -> HOLD -> FADE_OUT,
//               cycles the 4-entry word selector and produces a 3-bit text
//               brightness level for the pixel mixer.
// Ports       : clk         system / pixel clock
//               rst         asynchronous active-high reset
//               frame_tick  one-clk pulse per frame (start of vblank)
//               pause       level, 1 = freeze all sequencing (ticks dropped)
//               skip        one-clk pulse, request early end of MUNCH or HOLD
//               counter     munch animation counter (mod 128)
//               selector    word index for text_sequencer (mod 4)
//               text_level  text brightness 0..7
//               text_en     text layer enable  (phase != MUNCH)
//               munch_en    munch layer enable (phase != HOLD)
//               phase       0=MUNCH 1=FADE_IN 2=HOLD 3=FADE_OUT
// Revision    : 1.0 - initial release
// ============================================================================
module scene_sequencer #(
    parameter int unsigned MUNCH_FRAMES = 240,
    parameter int unsigned FADE_STEP    = 4,
    parameter int unsigned HOLD_FRAMES  = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       pause,
    input  logic       skip,
    output logic [6:0] counter,
    output logic [1:0] selector,
    output logic [2:0] text_level,
    output logic       text_en,
    output logic       munch_en,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        S_MUNCH    = 2'd0,
        S_FADE_IN  = 2'd1,
        S_HOLD     = 2'd2,
        S_FADE_OUT = 2'd3
    } state_t;

    // Terminal timer values: the phase event fires when the timer sits at
    // LIMIT-1 on an active tick.
    localparam logic [15:0] C_MUNCH_LAST = 16'(MUNCH_FRAMES - 1);
    localparam logic [15:0] C_FADE_LAST  = 16'(FADE_STEP - 1);
    localparam logic [15:0] C_HOLD_LAST  = 16'(HOLD_FRAMES - 1);
    localparam logic [2:0]  C_LEVEL_MAX  = 3'd7;
    localparam logic [2:0]  C_LEVEL_MIN  = 3'd0;

    state_t      r_state;
    logic [15:0] r_timer;
    logic        r_skip_pend;

    state_t      w_state_nxt;
    logic [15:0] w_timer_nxt;
    logic        w_skip_pend_nxt;
    logic [6:0]  w_counter_nxt;
    logic [1:0]  w_selector_nxt;
    logic [2:0]  w_level_nxt;
    logic        w_text_en_nxt;
    logic        w_munch_en_nxt;

    logic        w_active;
    logic        w_skip_req;
    logic [15:0] w_timer_last;
    logic        w_event;

    assign phase = r_state;

    // ------------------------------------------------------------------------
    // State register (all outputs are registered here)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_MUNCH;
            r_timer     <= 16'd0;
            r_skip_pend <= 1'b0;
            counter     <= 7'd0;
            selector    <= 2'd0;
            text_level  <= 3'd0;
            text_en     <= 1'b0;
            munch_en    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_skip_pend <= w_skip_pend_nxt;
            counter     <= w_counter_nxt;
            selector    <= w_selector_nxt;
            text_level  <= w_level_nxt;
            text_en     <= w_text_en_nxt;
            munch_en    <= w_munch_en_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_active        = frame_tick & ~pause;
        // A skip arriving on the same cycle as an active tick acts at once.
        w_skip_req      = r_skip_pend | skip;

        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_skip_pend_nxt = r_skip_pend | skip;
        w_counter_nxt   = counter;
        w_selector_nxt  = selector;
        w_level_nxt     = text_level;

        case (r_state)
            S_MUNCH:  w_timer_last = C_MUNCH_LAST;
            S_HOLD:   w_timer_last = C_HOLD_LAST;
            default:  w_timer_last = C_FADE_LAST;
        endcase
        w_event = (r_timer == w_timer_last);

        if (w_active) begin
            // Pending skip is consumed by every active tick, even in the
            // fade phases where it has no effect.
            w_skip_pend_nxt = 1'b0;
            w_counter_nxt   = counter + 7'd1;
            w_timer_nxt     = w_event ? 16'd0 : (r_timer + 16'd1);

            case (r_state)
                S_MUNCH: begin
                    if (w_skip_req || w_event) begin
                        w_state_nxt = S_FADE_IN;
                        w_timer_nxt = 16'd0;
                        w_level_nxt = C_LEVEL_MIN;
                    end
                end
                S_FADE_IN: begin
                    if (w_event) begin
                        // Eight steps total: seven increments, then one more
                        // step dwelling at full brightness before HOLD.
                        if (text_level != C_LEVEL_MAX) begin
                            w_level_nxt = text_level + 3'd1;
                        end else begin
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_skip_req || w_event) begin
                        w_state_nxt = S_FADE_OUT;
                        w_timer_nxt = 16'd0;
                        w_level_nxt = C_LEVEL_MAX;
                    end
                end
                S_FADE_OUT: begin
                    if (w_event) begin
                        if (text_level != C_LEVEL_MIN) begin
                            w_level_nxt = text_level - 3'd1;
                        end else begin
                            w_state_nxt    = S_MUNCH;
                            w_selector_nxt = selector + 2'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_MUNCH;
                end
            endcase
        end

        w_text_en_nxt  = (w_state_nxt != S_MUNCH);
        w_munch_en_nxt = (w_state_nxt != S_HOLD);
    end

endmodule
`default_nettype wire

// File: tb/tb_scene_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scene_sequencer
// Description : Scoreboard bench for scene_sequencer. Instance A uses short
//               timing (4/1/2), instance B the default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scene_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       pause;
    logic       skip;

    logic [6:0] a_counter,  b_counter;
    logic [1:0] a_selector, b_selector;
    logic [2:0] a_level,    b_level;
    logic       a_text_en,  b_text_en;
    logic       a_munch_en, b_munch_en;
    logic [1:0] a_phase,    b_phase;

    always #5 clk = ~clk;

    scene_sequencer #(
        .MUNCH_FRAMES (4),
        .FADE_STEP    (1),
        .HOLD_FRAMES  (2)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .pause      (pause),
        .skip       (skip),
        .counter    (a_counter),
        .selector   (a_selector),
        .text_level (a_level),
        .text_en    (a_text_en),
        .munch_en   (a_munch_en),
        .phase      (a_phase)
    );

    scene_sequencer dut_b (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .pause      (pause),
        .skip       (skip),
        .counter    (b_counter),
        .selector   (b_selector),
        .text_level (b_level),
        .text_en    (b_text_en),
        .munch_en   (b_munch_en),
        .phase      (b_phase)
    );

    localparam logic [4:0] M_PH  = 5'b00001;
    localparam logic [4:0] M_CNT = 5'b00010;
    localparam logic [4:0] M_SEL = 5'b00100;
    localparam logic [4:0] M_LVL = 5'b01000;
    localparam logic [4:0] M_EN  = 5'b10000;
    localparam logic [4:0] M_ALL = 5'b11111;

    typedef struct {
        string      name;
        int         dut;
        logic [4:0] mask;
        logic [1:0] ph;
        logic [6:0] cnt;
        logic [1:0] sel;
        logic [2:0] lvl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void push(string name, int dut, logic [4:0] mask,
                                 int ph, int cnt, int sel, int lvl);
        exp_t e;
        e.name = name;
        e.dut  = dut;
        e.mask = mask;
        e.ph   = 2'(ph);
        e.cnt  = 7'(cnt);
        e.sel  = 2'(sel);
        e.lvl  = 3'(lvl);
        sb.push_back(e);
    endfunction

    task automatic check_now(string name, int dut, int ph, int cnt, int sel, int lvl);
        logic [1:0] g_ph;
        logic [6:0] g_cnt;
        logic [1:0] g_sel;
        logic [2:0] g_lvl;
        logic       g_ten, g_men;
        if (dut == 0) begin
            g_ph = a_phase; g_cnt = a_counter; g_sel = a_selector;
            g_lvl = a_level; g_ten = a_text_en; g_men = a_munch_en;
        end else begin
            g_ph = b_phase; g_cnt = b_counter; g_sel = b_selector;
            g_lvl = b_level; g_ten = b_text_en; g_men = b_munch_en;
        end
        n_checks++;
        if ((g_ph === 2'(ph)) && (g_cnt === 7'(cnt)) && (g_sel === 2'(sel)) &&
            (g_lvl === 3'(lvl)) && (g_ten === (ph != 0)) && (g_men === (ph != 2))) begin
            n_pass++;
        end else begin
            $display("FAIL %s (direct): got phase=%0d cnt=%0d sel=%0d lvl=%0d ten=%0b men=%0b; want phase=%0d cnt=%0d sel=%0d lvl=%0d",
                     name, g_ph, g_cnt, g_sel, g_lvl, g_ten, g_men, ph, cnt, sel, lvl);
        end
    endtask

    exp_t       m_e;
    logic [1:0] m_ph;
    logic [6:0] m_cnt;
    logic [1:0] m_sel;
    logic [2:0] m_lvl;
    logic       m_ten, m_men, m_ok;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            if (m_e.dut == 0) begin
                m_ph = a_phase; m_cnt = a_counter; m_sel = a_selector;
                m_lvl = a_level; m_ten = a_text_en; m_men = a_munch_en;
            end else begin
                m_ph = b_phase; m_cnt = b_counter; m_sel = b_selector;
                m_lvl = b_level; m_ten = b_text_en; m_men = b_munch_en;
            end
            m_ok = 1'b1;
            if (m_e.mask[0] && (m_ph  !== m_e.ph))  m_ok = 1'b0;
            if (m_e.mask[1] && (m_cnt !== m_e.cnt)) m_ok = 1'b0;
            if (m_e.mask[2] && (m_sel !== m_e.sel)) m_ok = 1'b0;
            if (m_e.mask[3] && (m_lvl !== m_e.lvl)) m_ok = 1'b0;
            if (m_e.mask[4] && ((m_ten !== (m_e.ph != 2'd0)) ||
                                (m_men !== (m_e.ph != 2'd2)))) m_ok = 1'b0;
            n_checks++;
            if (m_ok) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got phase=%0d cnt=%0d sel=%0d lvl=%0d ten=%0b men=%0b; want phase=%0d cnt=%0d sel=%0d lvl=%0d ten=%0b men=%0b (mask %b)",
                         m_e.name, m_ph, m_cnt, m_sel, m_lvl, m_ten, m_men,
                         m_e.ph, m_e.cnt, m_e.sel, m_e.lvl,
                         (m_e.ph != 2'd0), (m_e.ph != 2'd2), m_e.mask);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic tick_n(int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic skip_pulse();
        @(negedge clk);
        skip = 1'b1;
        @(posedge clk);
        #1;
        skip = 1'b0;
    endtask

    initial begin
        int ph, lvl, sel;
        rst        = 1'b1;
        frame_tick = 1'b0;
        pause      = 1'b0;
        skip       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        @(posedge clk); #1;
        check_now("reset_a_direct", 0, 0, 0, 0, 0);
        check_now("reset_b_direct", 1, 0, 0, 0, 0);
        push("reset_a", 0, M_ALL, 0, 0, 0, 0);
        push("reset_b", 1, M_ALL, 0, 0, 0, 0);

        for (int t = 1; t <= 22; t++) begin
            tick();
            if (t < 4)       begin ph = 0; lvl = 0; end
            else if (t < 12) begin ph = 1; lvl = t - 4; end
            else if (t < 14) begin ph = 2; lvl = 7; end
            else if (t < 22) begin ph = 3; lvl = 7 - (t - 14); end
            else             begin ph = 0; lvl = 0; end
            sel = (t == 22) ? 1 : 0;
            push($sformatf("trace_t%0d", t), 0, M_ALL, ph, t, sel, lvl);
        end

        tick_n(105);
        push("cnt_127", 0, M_CNT, 0, 127, 0, 0);
        tick();
        push("cnt_wrap", 0, M_CNT, 0, 0, 0, 0);

        do_reset();
        tick_n(6);
        push("pre_pause", 0, M_ALL, 1, 6, 0, 2);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            push("paused", 0, M_ALL, 1, 6, 0, 2);
        end
        pause = 1'b0;
        tick();
        push("resume1", 0, M_ALL, 1, 7, 0, 3);
        tick();
        push("resume2", 0, M_ALL, 1, 8, 0, 4);

        do_reset();
        tick_n(2);
        pause = 1'b1;
        tick_n(10);
        pause = 1'b0;
        tick();
        push("munch_timer_frozen", 0, M_ALL, 0, 3, 0, 0);
        tick();
        push("munch_timer_resume", 0, M_ALL, 1, 4, 0, 0);

        do_reset();
        tick();
        push("skip_pre", 0, M_ALL, 0, 1, 0, 0);
        skip_pulse();
        check_now("skip_wait0_direct", 0, 0, 1, 0, 0);
        push("skip_wait0", 0, M_ALL, 0, 1, 0, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check_now("skip_wait_direct", 0, 0, 1, 0, 0);
            push("skip_wait", 0, M_ALL, 0, 1, 0, 0);
        end
        tick();
        push("skip_munch", 0, M_ALL, 1, 2, 0, 0);
        tick_n(10);
        push("fadeout_start", 0, M_ALL, 3, 12, 0, 7);

        skip_pulse();
        tick();
        push("skip_fadeout_ign", 0, M_ALL, 3, 13, 0, 6);
        tick_n(7);
        push("back_to_munch", 0, M_ALL, 0, 20, 1, 0);
        tick();
        push("skip_cleared", 0, M_ALL, 0, 21, 1, 0);
        tick_n(11);
        push("hold_again", 0, M_ALL, 2, 32, 1, 7);

        @(negedge clk);
        skip       = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        skip       = 1'b0;
        frame_tick = 1'b0;
        push("skip_hold_same", 0, M_ALL, 3, 33, 1, 7);
        tick();
        push("after_skip_hold", 0, M_ALL, 3, 34, 1, 6);
        tick_n(19);
        push("hold_sel2", 0, M_ALL, 2, 53, 2, 7);

        @(posedge clk); #1;
        rst = 1'b1;
        push("async_reset", 0, M_ALL, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        push("restart", 0, M_ALL, 0, 1, 0, 0);

        do_reset();
        tick_n(240);
        push("b_fadein", 1, M_ALL, 1, 112, 0, 0);
        tick_n(32);
        push("b_hold", 1, M_ALL, 2, 16, 0, 7);
        tick_n(152);
        push("b_cycle1", 1, M_ALL, 0, 40, 1, 0);
        tick_n(1271);
        push("b_last_fadeout", 1, M_ALL, 3, 31, 3, 0);
        tick();
        push("b_cycle4", 1, M_ALL, 0, 32, 0, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
